// File: rtl/sweep_pkg.sv
// Shared state encoding and direction constants for the sweep sequencer.
package sweep_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRunUp = 2'd1,
    StRunDn = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam logic DirUp = 1'b1;
  localparam logic DirDn = 1'b0;

endpackage

// File: rtl/updown_cnt_core.sv
// W-bit loadable up/down counter; load has priority over enable, steps wrap mod 2^W.
module updown_cnt_core #(
  parameter int unsigned W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  input  logic         updown_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i) begin
      count_d = updown_i ? count_q + W'(1) : count_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/sweep_ctrl.sv
// Sweep sequencer: drives an up/down counter lo->hi->lo for a latched number of sweeps.
module sweep_ctrl
  import sweep_pkg::*;
#(
  parameter int unsigned W     = 4,
  parameter int unsigned NSW_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [W-1:0]     lo_i,
  input  logic [W-1:0]     hi_i,
  input  logic [NSW_W-1:0] n_sweeps_i,
  output logic [W-1:0]     count_o,
  output logic             updown_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [NSW_W-1:0] sweeps_done_o
);

  state_e           state_q, state_d;
  logic [W-1:0]     lo_q, lo_d, hi_q, hi_d;
  logic [NSW_W-1:0] n_q, n_d, sweeps_q, sweeps_d;
  logic             err_q, err_d;
  logic             load, en;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      lo_q     <= '0;
      hi_q     <= '0;
      n_q      <= '0;
      sweeps_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      n_q      <= n_d;
      sweeps_q <= sweeps_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    n_d      = n_q;
    sweeps_d = sweeps_q;
    err_d    = 1'b0;
    load     = 1'b0;
    en       = 1'b0;
    unique case (state_q)
      StIdle: begin
        // abort masks start entirely, including the error check
        if (start_i && !abort_i) begin
          if (lo_i >= hi_i || n_sweeps_i == '0) begin
            err_d = 1'b1;
          end else begin
            lo_d     = lo_i;
            hi_d     = hi_i;
            n_d      = n_sweeps_i;
            sweeps_d = '0;
            load     = 1'b1;
            state_d  = StRunUp;
          end
        end
      end
      StRunUp: begin
        if (abort_i) begin
          state_d = StIdle;
        end else begin
          en = 1'b1;
          if (count_o + W'(1) == hi_q) state_d = StRunDn;
        end
      end
      StRunDn: begin
        if (abort_i) begin
          state_d = StIdle;
        end else begin
          en = 1'b1;
          if (count_o - W'(1) == lo_q) begin
            sweeps_d = sweeps_q + NSW_W'(1);
            state_d  = (sweeps_q + NSW_W'(1) == n_q) ? StDone : StRunUp;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    busy_o        = (state_q == StRunUp) || (state_q == StRunDn);
    done_o        = (state_q == StDone);
    updown_o      = (state_q == StRunDn) ? DirDn : DirUp;
    err_o         = err_q;
    sweeps_done_o = sweeps_q;
  end

  updown_cnt_core #(
    .W(W)
  ) u_core (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (load),
    .load_val_i (lo_i),
    .en_i       (en),
    .updown_i   (updown_o),
    .count_o    (count_o)
  );

endmodule

// File: tb/tb_sweep_ctrl.sv
// Bench for sweep_ctrl: expected waveforms are built from the sweep rules as value lists.
module tb_sweep_ctrl;

  localparam int W     = 4;
  localparam int NSW_W = 4;

  logic             clk = 1'b0;
  logic             rst, start, abort;
  logic [W-1:0]     lo, hi;
  logic [NSW_W-1:0] nsw;
  logic [W-1:0]     count;
  logic             updown, busy, done, err;
  logic [NSW_W-1:0] sweeps_done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int cnt;
    bit up;
    bit bsy;
    bit dn;
    int sw;
  } exp_t;

  always #5 clk = ~clk;

  sweep_ctrl #(
    .W    (W),
    .NSW_W(NSW_W)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .abort_i      (abort),
    .lo_i         (lo),
    .hi_i         (hi),
    .n_sweeps_i   (nsw),
    .count_o      (count),
    .updown_o     (updown),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err),
    .sweeps_done_o(sweeps_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; lo = '0; hi = '0; nsw = '0;
    tick();
    tick();
    rst = 1'b0;
    total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
    total++; if (updown !== 1'b1) begin bad++; $display("FAIL reset_updown: got %b want 1", updown); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
    total++;
    if (sweeps_done !== 4'd0) begin
      bad++; $display("FAIL reset_sweeps: got %0d want 0", sweeps_done);
    end
  endtask

  // Count is 0 on entry (right after reset) and must stay there through every rejection.
  task automatic test_err();
    int l_tab [3] = '{7, 1, 9};
    int h_tab [3] = '{7, 3, 3};
    int n_tab [3] = '{1, 0, 2};
    for (int k = 0; k < 3; k++) begin
      lo = W'(l_tab[k]); hi = W'(h_tab[k]); nsw = NSW_W'(n_tab[k]); start = 1'b1;
      tick();
      start = 1'b0;
      total++;
      if (err !== 1'b1 || busy !== 1'b0 || count !== 4'd0) begin
        bad++;
        $display("FAIL err_pulse%0d: got err=%b busy=%b count=%0d want err=1 busy=0 count=0",
                 k, err, busy, count);
      end
      tick();
      total++;
      if (err !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL err_width%0d: got err=%b busy=%b want err=0 busy=0", k, err, busy);
      end
    end
  endtask

  // Full run from an idle DUT; with noise, start/lo/hi/n are scrambled while the run is active.
  task automatic test_sweep(input int l, input int h, input int n, input bit noise,
                            input string name);
    exp_t q[$];
    int   done_at = -1;
    q.push_back('{l, 1'b1, 1'b1, 1'b0, 0});
    for (int s = 0; s < n; s++) begin
      for (int v = l + 1; v <= h; v++) q.push_back('{v, (v == h) ? 1'b0 : 1'b1, 1'b1, 1'b0, s});
      for (int v = h - 1; v >= l; v--) begin
        if (v > l)          q.push_back('{v, 1'b0, 1'b1, 1'b0, s});
        else if (s < n - 1) q.push_back('{v, 1'b1, 1'b1, 1'b0, s + 1});
        else                q.push_back('{v, 1'b1, 1'b0, 1'b1, s + 1});
      end
    end
    q.push_back('{l, 1'b1, 1'b0, 1'b0, n});
    lo = W'(l); hi = W'(h); nsw = NSW_W'(n); abort = 1'b0; start = 1'b1;
    for (int i = 0; i < q.size(); i++) begin
      tick();
      if (i == 0) start = 1'b0;
      total++;
      if (count !== W'(q[i].cnt) || updown !== q[i].up || busy !== q[i].bsy ||
          done !== q[i].dn || err !== 1'b0 || sweeps_done !== NSW_W'(q[i].sw)) begin
        bad++;
        $display("FAIL %s cyc%0d: got cnt=%0d up=%b busy=%b done=%b err=%b sw=%0d want cnt=%0d up=%b busy=%b done=%b err=0 sw=%0d",
                 name, i, count, updown, busy, done, err, sweeps_done,
                 q[i].cnt, q[i].up, q[i].bsy, q[i].dn, q[i].sw);
      end
      if (done === 1'b1 && done_at < 0) done_at = i + 1;
      if (noise && i < q.size() - 1) begin
        start = 1'($urandom_range(0, 1));
        lo    = W'($urandom);
        hi    = W'($urandom);
        nsw   = NSW_W'($urandom);
      end
    end
    start = 1'b0;
    total++;
    if (done_at != 1 + n * 2 * (h - l)) begin
      bad++; $display("FAIL %s_done_clk: got %0d want %0d", name, done_at, 1 + n * 2 * (h - l));
    end
  endtask

  task automatic test_abort();
    int k = 0;
    lo = 4'd2; hi = 4'd9; nsw = 4'd2; start = 1'b1; abort = 1'b0;
    tick();
    start = 1'b0;
    while (count !== 4'd6 && k < 20) begin tick(); k++; end
    total++;
    if (count !== 4'd6) begin bad++; $display("FAIL abort_reach6: got %0d want 6", count); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++;
    if (busy !== 1'b0 || count !== 4'd6 || done !== 1'b0 || sweeps_done !== 4'd0) begin
      bad++;
      $display("FAIL abort_stop: got busy=%b count=%0d done=%b sw=%0d want busy=0 count=6 done=0 sw=0",
               busy, count, done, sweeps_done);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if (busy !== 1'b0 || count !== 4'd6 || done !== 1'b0) begin
        bad++;
        $display("FAIL abort_hold%0d: got busy=%b count=%0d done=%b want busy=0 count=6 done=0",
                 c, busy, count, done);
      end
    end
    // start and abort together in idle: neither a run nor an error
    lo = 4'd0; hi = 4'd5; nsw = 4'd1; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    for (int c = 0; c < 2; c++) begin
      total++;
      if (busy !== 1'b0 || err !== 1'b0 || count !== 4'd6) begin
        bad++;
        $display("FAIL start_abort%0d: got busy=%b err=%b count=%0d want busy=0 err=0 count=6",
                 c, busy, err, count);
      end
      tick();
    end
  endtask

  task automatic test_reset_midrun();
    int k = 0;
    lo = 4'd1; hi = 4'd8; nsw = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    while (count !== 4'd4 && k < 20) begin tick(); k++; end
    total++;
    if (count !== 4'd4 || busy !== 1'b1) begin
      bad++; $display("FAIL midrun_reach4: got count=%0d busy=%b want 4 1", count, busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (count !== 4'd0 || busy !== 1'b0 || updown !== 1'b1 || done !== 1'b0 ||
        err !== 1'b0 || sweeps_done !== 4'd0) begin
      bad++;
      $display("FAIL midrun_rst: got cnt=%0d busy=%b up=%b done=%b err=%b sw=%0d want 0 0 1 0 0 0",
               count, busy, updown, done, err, sweeps_done);
    end
    tick();
    total++;
    if (count !== 4'd0 || busy !== 1'b0) begin
      bad++; $display("FAIL midrun_idle: got count=%0d busy=%b want 0 0", count, busy);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      int l = $urandom_range(0, 14);
      int h = $urandom_range(l + 1, 15);
      int n = $urandom_range(1, 3);
      test_sweep(l, h, n, 1'b1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_err();
    test_sweep(2, 5, 1, 1'b0, "basic");
    test_sweep(0, 15, 3, 1'b0, "full_range");
    test_abort();
    test_reset_midrun();
    test_sweep(3, 4, 2, 1'b1, "min_span");
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
